// File: rtl/cpu_cycle_controller_if.sv
// Control/status bundle between the cycle controller and the CPU datapath.
// InstrCount exists only when CPU_CTRL_PERF_EN is defined.
interface cpu_cycle_controller_if #(
    parameter int OPW  = 4,
    parameter int ST_W = 3
);
    logic [OPW-1:0]  Opcode;
    logic            Zero;
    logic            MemReady;
    logic            PCWrite;
    logic [1:0]      PCSel;
    logic            IRWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            IorD;
    logic            RegWrite;
    logic            MemToReg;
    logic            ALUSrcB;
    logic [1:0]      ALUOp;
    logic            Halted;
    logic [ST_W-1:0] State;
`ifdef CPU_CTRL_PERF_EN
    logic [23:0]     InstrCount;
`endif

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCSel, IRWrite, MemRead, MemWrite, IorD,
        output RegWrite, MemToReg, ALUSrcB, ALUOp, Halted, State
`ifdef CPU_CTRL_PERF_EN
        , output InstrCount
`endif
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCSel, IRWrite, MemRead, MemWrite, IorD,
        input  RegWrite, MemToReg, ALUSrcB, ALUOp, Halted, State
`ifdef CPU_CTRL_PERF_EN
        , input InstrCount
`endif
    );
endinterface

// File: rtl/cpu_cycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 24-bit CPU.
// Define CPU_CTRL_PERF_EN to add the InstrCount retire counter.
module cpu_cycle_controller #(
    parameter int OPW  = 4,
    parameter int ST_W = 3
) (
    input logic                    Clock,
    input logic                    Reset,
    cpu_cycle_controller_if.master bus
);
    typedef enum logic [ST_W-1:0] {
        S_FETCH  = ST_W'(0),
        S_DECODE = ST_W'(1),
        S_EXEC   = ST_W'(2),
        S_MEM    = ST_W'(3),
        S_WB     = ST_W'(4),
        S_HALT   = ST_W'(5)
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_LW   = OPW'(2);
    localparam logic [OPW-1:0] OP_SW   = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
    localparam logic [OPW-1:0] OP_J    = OPW'(5);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;

    logic       pc_write;
    logic [1:0] pc_sel;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       halted;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_write   = 1'b0;
        pc_sel     = 2'd0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'd0;
        halted     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = bus.Opcode;
                unique case (bus.Opcode)
                    OP_R, OP_ADDI, OP_LW,
                    OP_SW, OP_BEQ, OP_J: state_d = S_EXEC;
                    OP_HALT:             state_d = S_HALT;
                    default:             state_d = S_FETCH;
                endcase
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_R: begin
                        alu_op  = 2'd2;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src_b = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = 2'd1;
                        pc_sel   = 2'd1;
                        pc_write = bus.Zero;
                        state_d  = S_FETCH;
                    end
                    OP_J: begin
                        pc_sel   = 2'd2;
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (bus.MemReady)
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces every output low at once, independent of the clock.
    assign bus.PCWrite  = pc_write & ~Reset;
    assign bus.PCSel    = Reset ? 2'd0 : pc_sel;
    assign bus.IRWrite  = ir_write & ~Reset;
    assign bus.MemRead  = mem_read & ~Reset;
    assign bus.MemWrite = mem_write & ~Reset;
    assign bus.IorD     = iord & ~Reset;
    assign bus.RegWrite = reg_write & ~Reset;
    assign bus.MemToReg = mem_to_reg & ~Reset;
    assign bus.ALUSrcB  = alu_src_b & ~Reset;
    assign bus.ALUOp    = Reset ? 2'd0 : alu_op;
    assign bus.Halted   = halted & ~Reset;
    assign bus.State    = state_q;

`ifdef CPU_CTRL_PERF_EN
    logic        retire;
    logic        dec_nop;
    logic [23:0] instr_cnt_q, instr_cnt_d;

    assign dec_nop = !(bus.Opcode inside
                       {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT});

    assign retire =
        (state_q == S_WB) ||
        (state_q == S_MEM && op_q == OP_SW && bus.MemReady) ||
        (state_q == S_EXEC && (op_q == OP_BEQ || op_q == OP_J)) ||
        (state_q == S_DECODE && dec_nop);

    assign instr_cnt_d = retire ? instr_cnt_q + 24'd1 : instr_cnt_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) instr_cnt_q <= '0;
        else       instr_cnt_q <= instr_cnt_d;
    end

    assign bus.InstrCount = instr_cnt_q;
`endif
endmodule

// File: tb/tb_cpu_cycle_controller.sv
// Directed vector bench for cpu_cycle_controller.
// Retire-counter checks compile in when CPU_CTRL_PERF_EN is defined.
module tb_cpu_cycle_controller;
    logic Clock = 1'b0;
    logic Reset = 1'b1;

    cpu_cycle_controller_if bus ();

    cpu_cycle_controller dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        z;
        logic        mr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t tv[$];

    logic [15:0] obs;
    assign obs = {bus.State, bus.PCWrite, bus.PCSel, bus.IRWrite,
                  bus.MemRead, bus.MemWrite, bus.IorD, bus.RegWrite,
                  bus.MemToReg, bus.ALUSrcB, bus.ALUOp, bus.Halted};

    function automatic logic [15:0] ex(
        input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
        input logic irw, input logic mrd, input logic mwr,
        input logic iord, input logic rw, input logic m2r,
        input logic srcb, input logic [1:0] aop, input logic h);
        return {st, pcw, pcs, irw, mrd, mwr, iord, rw, m2r, srcb, aop, h};
    endfunction

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] op,
                       input logic z, input logic mr,
                       input logic [15:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.mr = mr;
        v.exp = exp; v.name = name;
        tv.push_back(v);
    endtask

    logic [15:0] ZERO, FGO, FST, DEC, HLT, SWM;

    initial begin
        bus.Opcode   = 4'd0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;

        ZERO = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        FGO  = ex(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        FST  = ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        DEC  = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        HLT  = ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        SWM  = ex(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        add(1, 0, 0, 1, ZERO, "reset_a");
        add(1, 0, 0, 1, ZERO, "reset_b");
        add(0, 0, 0, 1, FGO, "r_fetch");
        add(0, 0, 0, 1, DEC, "r_dec");
        add(0, 9, 1, 1, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "r_exec");
        add(0, 9, 0, 1, ex(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "r_wb");
        add(0, 0, 0, 0, FST, "lw_fstall");
        add(0, 0, 0, 1, FGO, "lw_fetch");
        add(0, 2, 0, 1, DEC, "lw_dec");
        add(0, 0, 0, 1, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "lw_exec");
        add(0, 0, 0, 0, ex(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "lw_mem0");
        add(0, 0, 0, 0, ex(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "lw_mem1");
        add(0, 0, 0, 1, ex(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "lw_mem2");
        add(0, 0, 0, 1, ex(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "lw_wb");
        add(0, 0, 0, 1, FGO, "beq1_fetch");
        add(0, 4, 0, 1, DEC, "beq1_dec");
        add(0, 0, 1, 1, ex(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "beq1_exec");
        add(0, 0, 0, 1, FGO, "beq0_fetch");
        add(0, 4, 1, 1, DEC, "beq0_dec");
        add(0, 0, 0, 1, ex(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "beq0_exec");
        add(0, 0, 0, 1, FGO, "j_fetch");
        add(0, 5, 0, 1, DEC, "j_dec");
        add(0, 0, 0, 1, ex(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "j_exec");
        add(0, 0, 0, 1, FGO, "nop_fetch");
        add(0, 7, 0, 1, DEC, "nop_dec");
        add(0, 0, 0, 1, FGO, "nop_back");
        add(0, 1, 0, 1, DEC, "addi_dec");
        add(0, 0, 0, 1, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "addi_exec");
        add(0, 0, 0, 1, ex(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "addi_wb");
        add(0, 0, 0, 1, FGO, "sw_fetch");
        add(0, 3, 0, 1, DEC, "sw_dec");
        add(0, 0, 0, 1, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sw_exec");
        add(0, 0, 0, 1, SWM, "sw_mem");
        add(0, 0, 0, 1, FGO, "halt_fetch");
        add(0, 15, 0, 1, DEC, "halt_dec");
        add(0, 0, 0, 1, HLT, "halt_enter");

        foreach (tv[i]) begin
            @(negedge Clock);
            Reset        = tv[i].rst;
            bus.Opcode   = tv[i].op;
            bus.Zero     = tv[i].z;
            bus.MemReady = tv[i].mr;
            #1;
            chk(tv[i].name, obs, tv[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            bus.Opcode   = 4'($urandom_range(0, 15));
            bus.Zero     = i[0];
            bus.MemReady = ~i[0];
            #1;
            chk("halt_hold", obs, HLT);
        end

        @(negedge Clock);
        Reset        = 1'b1;
        bus.MemReady = 1'b1;
        #1;
        chk("halt_reset", obs, ZERO);

        @(negedge Clock);
        Reset      = 1'b0;
        bus.Opcode = 4'd3;
        @(negedge Clock);
        #1;
        chk("swr_dec", obs, DEC);
        @(negedge Clock);
        bus.MemReady = 1'b0;
        @(negedge Clock);
        #1;
        chk("swr_stall", obs, SWM);
        #2;
        Reset = 1'b1;
        #1;
        chk("swr_async", obs, ZERO);
        @(negedge Clock);
        #1;
        chk("swr_held", obs, ZERO);
        @(negedge Clock);
        Reset        = 1'b0;
        bus.MemReady = 1'b1;
        bus.Opcode   = 4'd0;
        #1;
        chk("swr_restart", obs, FGO);

`ifdef CPU_CTRL_PERF_EN
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("perf_rst", {8'd0, bus.InstrCount[7:0]}, 16'd0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (30) @(posedge Clock);
        @(negedge Clock);
        chk("perf_count", bus.InstrCount[15:0], 16'd7);
        chk("perf_hi", {8'd0, bus.InstrCount[23:16]}, 16'd0);
        force dut.instr_cnt_q = 24'hFFFFFF;
        #1;
        release dut.instr_cnt_q;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("perf_wrap_lo", bus.InstrCount[15:0], 16'd0);
        chk("perf_wrap_hi", {8'd0, bus.InstrCount[23:16]}, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
